m_ingress_arb: RTL

Packet-granular round-robin arbiter that shares the single ingress port of the `m` packet pipeline (`in_vld_w`/`in_w`) between `N` independent packet sources. Once a source wins with a start-of-packet beat, it holds the port until its end-of-packet beat is accepted, so packets are never interleaved. The block sits directly in front of `u_m`. It registers the selected beat onto the pipeline's `m_pkg::in_t` ingress bus and reports protocol violations by the sources.

---
 rtl/m_pkg.sv | 11 +
 rtl/m_ingress_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/m_pkg.sv
// rtl/m_pkg.sv - ingress beat type shared by the m packet pipeline and its arbiter
package m_pkg;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] length;
    logic [31:0] data;
  } in_t;

endpackage

// File: rtl/m_ingress_arb.sv
// rtl/m_ingress_arb.sv - packet-granular round-robin arbiter in front of the m ingress port
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_vld_w[N]    per-source beat valid
//   req_w[N]        per-source beat (sop, eop, length, data)
//   req_accept_w[N] combinational one-hot accept of the beat presented this cycle
//   out_vld_r       registered beat valid toward m.in_vld_w
//   out_r           registered beat toward m.in_w (holds when out_vld_r is 0)
//   busy_r          a packet is in progress
//   owner_r         source holding the port, meaningful while busy_r
//   err_sop_r       pulse: owner presented sop in the middle of a packet
//   err_orphan_r    pulse: non-sop beat presented while idle was dropped
//   drop_cnt_r      saturating count of dropped orphan beats
module m_ingress_arb #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_vld_w,
  input  m_pkg::in_t               req_w [N],
  output logic [N-1:0]             req_accept_w,
  output logic                     out_vld_r,
  output m_pkg::in_t               out_r,
  output logic                     busy_r,
  output logic [$clog2(N)-1:0]     owner_r,
  output logic                     err_sop_r,
  output logic                     err_orphan_r,
  output logic [CNT_W-1:0]         drop_cnt_r
);

  localparam int PW = $clog2(N);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        state_r;
  state_t        state_nxt;
  logic [PW-1:0] rr_ptr_r;

  logic [N-1:0]  cand;
  logic [N-1:0]  orph;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic          orph_found;
  logic [PW-1:0] orph_idx;
  int            idx;

  logic          fwd;
  logic          drop;
  logic          sop_err;
  logic [PW-1:0] sel;

  // Classify every source: sop beats compete for the port, non-sop beats are orphans while idle.
  always_comb begin
    cand = '0;
    orph = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = req_vld_w[i] &  req_w[i].sop;
      orph[i] = req_vld_w[i] & ~req_w[i].sop;
    end
  end

  // Circular search starting one past the last winner; the last step (k == N)
  // revisits the last winner itself so it can win again when alone.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr_r) + k) % N;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Lowest-index orphan: scanning downward leaves the smallest index last.
  always_comb begin
    orph_found = 1'b0;
    orph_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (orph[i]) begin
        orph_found = 1'b1;
        orph_idx   = PW'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next state; a sop+eop winner is a whole packet, so the port never becomes busy.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (win_found && !req_w[win_idx].eop) begin
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (req_vld_w[owner_r] && req_w[owner_r].eop) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: accept vector and what happens to the accepted beat.
  always_comb begin
    req_accept_w = '0;
    fwd          = 1'b0;
    drop         = 1'b0;
    sop_err      = 1'b0;
    sel          = win_idx;
    if (!rst) begin
      case (state_r)
        S_IDLE: begin
          if (win_found) begin
            req_accept_w[win_idx] = 1'b1;
            fwd                   = 1'b1;
          end else if (orph_found) begin
            req_accept_w[orph_idx] = 1'b1;
            drop                   = 1'b1;
          end
        end
        S_BUSY: begin
          sel = owner_r;
          if (req_vld_w[owner_r]) begin
            req_accept_w[owner_r] = 1'b1;
            fwd                   = 1'b1;
            sop_err               = req_w[owner_r].sop;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_r = (state_r == S_BUSY);

  // Arbitration bookkeeping, forwarding register and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r     <= PW'(N - 1);
      owner_r      <= '0;
      out_vld_r    <= 1'b0;
      out_r        <= '0;
      err_sop_r    <= 1'b0;
      err_orphan_r <= 1'b0;
      drop_cnt_r   <= '0;
    end else begin
      if (state_r == S_IDLE && win_found) begin
        rr_ptr_r <= win_idx;
        owner_r  <= win_idx;
      end
      out_vld_r <= fwd;
      if (fwd) begin
        out_r <= req_w[sel];
      end
      err_sop_r    <= sop_err;
      err_orphan_r <= drop;
      if (drop && drop_cnt_r != {CNT_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule
